// File: rtl/ctrl_bubble_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_bubble_pipe_pkg
// Shared pipeline definitions for the ID->EX control bubble logic:
//   - bp_state_e       : FSM state encoding (RUN / BUBBLE)
//   - LU_BUBBLES_MIN/MAX: legal range of bubbles inserted per load-use hazard
//   - REM_W            : width of the remaining-bubble down-counter
//   - BUBBLE_CTRL      : all-zero control bundle, sliced to CTRL_W by users
//   - lu_clamp()       : folds an out-of-range bubble count into the legal range
// No ports (package).
// ---------------------------------------------------------------------------
package ctrl_bubble_pipe_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } bp_state_e;

    localparam int LU_BUBBLES_MIN = 1;
    localparam int LU_BUBBLES_MAX = 7;

    // Holds LU_BUBBLES_MAX-1, the largest value ever loaded into rem.
    localparam int REM_W = 3;

    // Wide enough for any control bundle in this pipeline; users slice it.
    localparam int CTRL_W_MAX = 256;
    localparam logic [CTRL_W_MAX-1:0] BUBBLE_CTRL = '0;

    function automatic int lu_clamp(input int n);
        if (n < LU_BUBBLES_MIN) return LU_BUBBLES_MIN;
        if (n > LU_BUBBLES_MAX) return LU_BUBBLES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/ctrl_bubble_pipe_lu_hazard_detect.sv
// ---------------------------------------------------------------------------
// lu_hazard_detect
// Purely combinational load-use comparator. Flags a hazard when the consumer
// is a real instruction, the producer in EX is a load, the producer writes a
// non-zero register, and that register is one of the consumer's sources.
// Shared by the bubble controller and the forwarding logic.
// Ports:
//   valid   in  1       consumer holds a real instruction
//   is_load in  1       producer is a load
//   rd      in  REG_AW  producer destination register
//   rs, rt  in  REG_AW  consumer source registers
//   hazard  out 1       load-use hazard present
// ---------------------------------------------------------------------------
module lu_hazard_detect
    import ctrl_bubble_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              valid,
    input  logic              is_load,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    output logic              hazard
);

    logic rd_nonzero;
    logic rd_match;

    // Register 0 is hard-wired zero, so a load targeting it never conflicts.
    assign rd_nonzero = (rd != '0);
    assign rd_match   = (rd == rs) || (rd == rt);
    assign hazard     = valid && is_load && rd_nonzero && rd_match;

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_bubble_pipe
// ID->EX control register with load-use bubble insertion. A hazard replaces
// the EX control with an all-zero bubble and freezes PC and IF/ID for
// LU_BUBBLES cycles; the held instruction is then re-evaluated. Flush kills
// ID (bubble, holds released); ext_stall freezes everything and wins over
// flush. bubble_cnt counts loaded bubbles and saturates.
// Ports:
//   clk, rst            in   clock, asynchronous active-high reset
//   id_ctrl             in   CTRL_W  decoded control of instruction in ID
//   id_valid            in   1       ID holds a real instruction
//   id_rs, id_rt        in   REG_AW  ID source registers
//   ex_rd               in   REG_AW  EX destination register
//   ex_is_load          in   1       EX instruction is a load
//   flush               in   1       branch taken, kill ID
//   ext_stall           in   1       external freeze
//   ex_ctrl             out  CTRL_W  registered control into EX
//   ex_valid            out  1       ex_ctrl is a real instruction
//   pc_hold, ifid_hold  out  1       freeze PC and IF/ID
//   bubble_cnt          out  STAT_W  saturating bubble count since reset
// ---------------------------------------------------------------------------
module ctrl_bubble_pipe
    import ctrl_bubble_pipe_pkg::*;
#(
    parameter int CTRL_W     = 10,
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_valid,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic [STAT_W-1:0] bubble_cnt
);

    // An illegal LU_BUBBLES is folded into 1..7 rather than overflowing rem.
    localparam int               LU_EFF   = lu_clamp(LU_BUBBLES);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(LU_EFF - 1);
    localparam logic [CTRL_W-1:0] BUBBLE  = BUBBLE_CTRL[CTRL_W-1:0];
    localparam bit               MULTI    = (LU_EFF > 1);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    bp_state_e         state, state_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic [CTRL_W-1:0] ctrl_p1, ctrl_n;
    logic              vld_p1, vld_n;
    logic [STAT_W-1:0] cnt, cnt_n;
    logic              load_bubble;
    logic              hold;
    logic              hazard;

    lu_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .valid   (id_valid),
        .is_load (ex_is_load),
        .rd      (ex_rd),
        .rs      (id_rs),
        .rt      (id_rt),
        .hazard  (hazard)
    );

    // ---- ID stage: next-state, bubble select and hold decisions ----
    always_comb begin
        state_n     = state;
        rem_n       = rem;
        ctrl_n      = ctrl_p1;
        vld_n       = vld_p1;
        load_bubble = 1'b0;
        hold        = 1'b0;

        if (ext_stall) begin
            // Everything frozen; any flush is re-presented after the stall.
            hold = 1'b1;
        end else if (flush) begin
            load_bubble = 1'b1;
            rem_n       = '0;
            state_n     = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        load_bubble = 1'b1;
                        hold        = 1'b1;
                        rem_n       = REM_LOAD;
                        state_n     = MULTI ? ST_BUBBLE : ST_RUN;
                    end else begin
                        ctrl_n = id_ctrl;
                        vld_n  = id_valid;
                    end
                end
                ST_BUBBLE: begin
                    // rem counts bubbles still owed after this one; leave
                    // BUBBLE on the edge where it reaches zero.
                    load_bubble = 1'b1;
                    hold        = 1'b1;
                    rem_n       = (rem == '0) ? '0 : rem - REM_W'(1);
                    state_n     = (rem <= REM_W'(1)) ? ST_RUN : ST_BUBBLE;
                end
                default: begin
                    state_n = ST_RUN;
                    rem_n   = '0;
                end
            endcase
        end

        if (load_bubble) begin
            ctrl_n = BUBBLE;
            vld_n  = 1'b0;
        end

        cnt_n = load_bubble ? sat_inc(cnt) : cnt;
    end

    // ---- EX stage boundary: control register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            rem     <= '0;
            ctrl_p1 <= '0;
            vld_p1  <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            ctrl_p1 <= ctrl_n;
            vld_p1  <= vld_n;
            cnt     <= cnt_n;
        end
    end

    assign ex_ctrl    = ctrl_p1;
    assign ex_valid   = vld_p1;
    // Holds are forced low while reset is asserted, independent of state.
    assign pc_hold    = hold && !rst;
    assign ifid_hold  = hold && !rst;
    assign bubble_cnt = cnt;

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_bubble_pipe
// Three instances share one stimulus stream:
//   dut0: LU_BUBBLES=1, STAT_W=16
//   dut1: LU_BUBBLES=3, STAT_W=16
//   dut2: LU_BUBBLES=1, STAT_W=2
// Registered outputs are predicted when stimulus is driven and compared one
// edge later; hold outputs are compared directly in the driving cycle.
// ---------------------------------------------------------------------------
module tb_ctrl_bubble_pipe;

    localparam int CW = 10;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] id_ctrl = '0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          ex_is_load = 1'b0, flush = 1'b0, ext_stall = 1'b0;

    logic [CW-1:0] ex_ctrl0, ex_ctrl1, ex_ctrl2;
    logic          ex_valid0, ex_valid1, ex_valid2;
    logic          pc_hold0, pc_hold1, pc_hold2;
    logic          ifid_hold0, ifid_hold1, ifid_hold2;
    logic [15:0]   cnt0, cnt1;
    logic [1:0]    cnt2;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        string         tag;
        int            sel;
        logic [CW-1:0] ctrl;
        logic          vld;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ctrl_bubble_pipe #(.CTRL_W(CW), .REG_AW(AW), .LU_BUBBLES(1), .STAT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .flush(flush), .ext_stall(ext_stall), .ex_ctrl(ex_ctrl0), .ex_valid(ex_valid0),
        .pc_hold(pc_hold0), .ifid_hold(ifid_hold0), .bubble_cnt(cnt0)
    );

    ctrl_bubble_pipe #(.CTRL_W(CW), .REG_AW(AW), .LU_BUBBLES(3), .STAT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .flush(flush), .ext_stall(ext_stall), .ex_ctrl(ex_ctrl1), .ex_valid(ex_valid1),
        .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .bubble_cnt(cnt1)
    );

    ctrl_bubble_pipe #(.CTRL_W(CW), .REG_AW(AW), .LU_BUBBLES(1), .STAT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .flush(flush), .ext_stall(ext_stall), .ex_ctrl(ex_ctrl2), .ex_valid(ex_valid2),
        .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .bubble_cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic [CW-1:0] c, output logic v,
                           output logic [15:0] n, output logic [1:0] h);
        case (sel)
            0: begin c = ex_ctrl0; v = ex_valid0; n = cnt0; h = {pc_hold0, ifid_hold0}; end
            1: begin c = ex_ctrl1; v = ex_valid1; n = cnt1; h = {pc_hold1, ifid_hold1}; end
            default: begin
                c = ex_ctrl2; v = ex_valid2; n = {14'd0, cnt2}; h = {pc_hold2, ifid_hold2};
            end
        endcase
    endtask

    task automatic chk_hold(input string tag, input int sel, input logic [1:0] exp);
        logic [CW-1:0] c;
        logic v;
        logic [15:0] n;
        logic [1:0] h;
        get_out(sel, c, v, n, h);
        chk(tag, {30'd0, h}, {30'd0, exp});
    endtask

    task automatic chk_now(input string tag, input int sel, input logic [CW-1:0] ec,
                           input logic ev, input logic [15:0] en, input logic [1:0] eh);
        logic [CW-1:0] c;
        logic v;
        logic [15:0] n;
        logic [1:0] h;
        get_out(sel, c, v, n, h);
        chk({tag, ".ctrl"}, {22'd0, c}, {22'd0, ec});
        chk({tag, ".vld"}, {31'd0, v}, {31'd0, ev});
        chk({tag, ".cnt"}, {16'd0, n}, {16'd0, en});
        chk({tag, ".hold"}, {30'd0, h}, {30'd0, eh});
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [CW-1:0] c,
                              input logic v, input logic [15:0] n);
        exp_t e;
        e.tag = tag; e.sel = sel; e.ctrl = c; e.vld = v; e.cnt = n;
        sb.push_back(e);
    endtask

    // Advance one edge and retire every prediction made for it.
    task automatic tick();
        exp_t e;
        logic [CW-1:0] c;
        logic v;
        logic [15:0] n;
        logic [1:0] h;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_out(e.sel, c, v, n, h);
            chk({e.tag, ".ctrl"}, {22'd0, c}, {22'd0, e.ctrl});
            chk({e.tag, ".vld"}, {31'd0, v}, {31'd0, e.vld});
            chk({e.tag, ".cnt"}, {16'd0, n}, {16'd0, e.cnt});
        end
    endtask

    task automatic drv(input logic [CW-1:0] c, input logic v, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic ld,
                       input logic fl, input logic st);
        @(negedge clk);
        id_ctrl = c; id_valid = v; id_rs = rs; id_rt = rt; ex_rd = rd;
        ex_is_load = ld; flush = fl; ext_stall = st;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_ctrl = '0; id_valid = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        ex_is_load = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sat_exp [5];
        sat_exp[0] = 16'd1; sat_exp[1] = 16'd2; sat_exp[2] = 16'd3;
        sat_exp[3] = 16'd3; sat_exp[4] = 16'd3;

        // Reset state, holds forced low even with ext_stall high.
        ext_stall = 1'b1; id_ctrl = 10'h155; id_valid = 1'b1;
        #1;
        chk_now("rst0", 0, '0, 1'b0, 16'd0, 2'b00);
        chk_now("rst1", 1, '0, 1'b0, 16'd0, 2'b00);
        chk_now("rst2", 2, '0, 1'b0, 16'd0, 2'b00);
        @(posedge clk);
        #1;
        chk("rst_edge_ctrl", {22'd0, ex_ctrl0}, 32'd0);

        // First transfer on the first edge after release.
        @(negedge clk);
        rst = 1'b0; ext_stall = 1'b0;
        #1;
        chk_hold("first_hold", 0, 2'b00);
        expect_out("first_xfer", 0, 10'h155, 1'b1, 16'd0);
        tick();

        // Load-use hazard, LU_BUBBLES=1.
        drv(10'h2AA, 1, 5, 0, 5, 1, 0, 0);
        chk_hold("lu1_hold", 0, 2'b11);
        expect_out("lu1_bubble", 0, '0, 1'b0, 16'd1);
        tick();
        drv(10'h2AA, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("lu1_release", 0, 2'b00);
        expect_out("lu1_issue", 0, 10'h2AA, 1'b1, 16'd1);
        tick();

        // Load-use hazard, LU_BUBBLES=3.
        do_reset();
        drv(10'h0F0, 1, 5, 0, 5, 1, 0, 0);
        chk_hold("lu3_hold_a", 1, 2'b11);
        expect_out("lu3_b1", 1, '0, 1'b0, 16'd1);
        tick();
        drv(10'h0F0, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("lu3_hold_b", 1, 2'b11);
        expect_out("lu3_b2", 1, '0, 1'b0, 16'd2);
        tick();
        drv(10'h0F0, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("lu3_hold_c", 1, 2'b11);
        expect_out("lu3_b3", 1, '0, 1'b0, 16'd3);
        tick();
        drv(10'h0F0, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("lu3_release", 1, 2'b00);
        expect_out("lu3_issue", 1, 10'h0F0, 1'b1, 16'd3);
        tick();

        // Non-hazard boundaries: rd=0, non-load match, invalid ID; then rt match.
        do_reset();
        drv(10'h3C3, 1, 0, 0, 0, 1, 0, 0);
        chk_hold("rd0_hold", 0, 2'b00);
        expect_out("rd0_pass", 0, 10'h3C3, 1'b1, 16'd0);
        tick();
        drv(10'h0C3, 1, 5, 9, 5, 0, 0, 0);
        chk_hold("noload_hold", 0, 2'b00);
        expect_out("noload_pass", 0, 10'h0C3, 1'b1, 16'd0);
        tick();
        drv(10'h1E1, 0, 5, 5, 5, 1, 0, 0);
        chk_hold("inval_hold", 0, 2'b00);
        expect_out("inval_pass", 0, 10'h1E1, 1'b0, 16'd0);
        tick();
        drv(10'h1E2, 1, 3, 6, 6, 1, 0, 0);
        chk_hold("rt_hold", 0, 2'b11);
        expect_out("rt_bubble", 0, '0, 1'b0, 16'd1);
        tick();

        // Flush during BUBBLE, then flush overriding a RUN hazard.
        do_reset();
        drv(10'h111, 1, 5, 0, 5, 1, 0, 0);
        expect_out("fl_b1", 1, '0, 1'b0, 16'd1);
        tick();
        drv(10'h111, 1, 5, 0, 5, 0, 1, 0);
        chk_hold("fl_hold", 1, 2'b00);
        expect_out("fl_bubble", 1, '0, 1'b0, 16'd2);
        tick();
        drv(10'h111, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("fl_run_hold", 1, 2'b00);
        expect_out("fl_run", 1, 10'h111, 1'b1, 16'd2);
        tick();
        drv(10'h222, 1, 5, 0, 5, 1, 1, 0);
        chk_hold("flhz_hold", 1, 2'b00);
        expect_out("flhz_bubble", 1, '0, 1'b0, 16'd3);
        tick();
        drv(10'h222, 1, 5, 0, 5, 0, 0, 0);
        expect_out("flhz_run", 1, 10'h222, 1'b1, 16'd3);
        tick();

        // ext_stall in RUN and for 4 cycles in BUBBLE (flush ignored meanwhile).
        do_reset();
        drv(10'h155, 1, 0, 0, 0, 0, 0, 0);
        expect_out("st_pass", 1, 10'h155, 1'b1, 16'd0);
        tick();
        drv(10'h0AA, 1, 0, 0, 0, 0, 0, 1);
        chk_hold("st_run_hold", 1, 2'b11);
        expect_out("st_run_frozen", 1, 10'h155, 1'b1, 16'd0);
        tick();
        drv(10'h0AA, 1, 5, 0, 5, 1, 0, 0);
        expect_out("st_b1", 1, '0, 1'b0, 16'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(10'h0AA, 1, 5, 0, 5, 0, (i == 2), 1);
            chk_hold("st_bub_hold", 1, 2'b11);
            expect_out("st_bub_frozen", 1, '0, 1'b0, 16'd1);
            tick();
        end
        drv(10'h0AA, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("st_resume_a", 1, 2'b11);
        expect_out("st_b2", 1, '0, 1'b0, 16'd2);
        tick();
        drv(10'h0AA, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("st_resume_b", 1, 2'b11);
        expect_out("st_b3", 1, '0, 1'b0, 16'd3);
        tick();
        drv(10'h0AA, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("st_release", 1, 2'b00);
        expect_out("st_issue", 1, 10'h0AA, 1'b1, 16'd3);
        tick();

        // Persisting hazard re-triggers; 2-bit counter saturates at 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(10'h3FF, 1, 1, 7, 7, 1, 0, 0);
            chk_hold("sat_hold", 2, 2'b11);
            expect_out("sat_cnt", 2, '0, 1'b0, sat_exp[i]);
            tick();
        end
        drv(10'h3FF, 1, 1, 7, 7, 0, 0, 0);
        expect_out("sat_issue", 2, 10'h3FF, 1'b1, 16'd3);
        tick();

        // Reset asserted mid-BUBBLE clears at once and abandons the bubbles.
        do_reset();
        drv(10'h0F0, 1, 5, 0, 5, 1, 0, 0);
        expect_out("mid_b1", 1, '0, 1'b0, 16'd1);
        tick();
        drv(10'h0F0, 1, 5, 0, 5, 0, 0, 0);
        chk_hold("mid_pre_hold", 1, 2'b11);
        rst = 1'b1;
        #1;
        chk_now("mid_rst", 1, '0, 1'b0, 16'd0, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_hold("mid_post_hold", 1, 2'b00);
        expect_out("mid_issue", 1, 10'h0F0, 1'b1, 16'd0);
        tick();

        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
